// File: rtl/fourier_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : fourier_analyzer
// Purpose  : Lock-in / Fourier coefficient engine. Multiplies signed ADC
//            samples by signed DDS reference samples and accumulates the
//            products over a programmable frame length, emitting one result
//            per frame on an AXI-Stream master.
// Revision : 1.0 - initial release
// ============================================================================
module fourier_analyzer #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int ADC_WIDTH        = 14,
    parameter int CFG_DATA_WIDTH   = 32,
    parameter int ACC_WIDTH        = 48
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata_adc,
    input  logic                        s_axis_tvalid_adc,
    output logic                        s_axis_tready_adc,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata_ref,
    input  logic                        s_axis_tvalid_ref,
    output logic                        s_axis_tready_ref,
    input  logic [CFG_DATA_WIDTH-1:0]   n_samples,
    input  logic                        enable,
    output logic [ACC_WIDTH-1:0]        m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        overrun
);

    localparam int PROD_WIDTH = ADC_WIDTH + AXIS_TDATA_WIDTH;
    localparam logic [CFG_DATA_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                      state_q;
    logic [CFG_DATA_WIDTH-1:0]   cnt_q;
    logic [CFG_DATA_WIDTH-1:0]   cnt_d;
    logic [CFG_DATA_WIDTH-1:0]   frame_len_q;

    // Input capture stage
    logic signed [ADC_WIDTH-1:0]        adc_q;
    logic signed [AXIS_TDATA_WIDTH-1:0] ref_q;
    logic                               s0_vld_q;
    logic                               s0_last_q;

    // Product stage
    logic signed [PROD_WIDTH-1:0] prod_q;
    logic                         s1_vld_q;
    logic                         s1_last_q;

    // Accumulate / output stage
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0]        res_q;
    logic                        res_vld_q;
    logic                        overrun_q;

    logic                         w_accept;
    logic                         w_last;
    logic                         w_close;
    logic signed [PROD_WIDTH-1:0] w_adc_ext;
    logic signed [PROD_WIDTH-1:0] w_ref_ext;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_sum;

    // The input streams are never back-pressured.
    assign s_axis_tready_adc = 1'b1;
    assign s_axis_tready_ref = 1'b1;

    // ADC bits above ADC_WIDTH carry no sample information.
    generate
        if (ADC_WIDTH < AXIS_TDATA_WIDTH) begin : g_adc_msbs
            logic unused_adc_msbs;
            assign unused_adc_msbs = ^s_axis_tdata_adc[AXIS_TDATA_WIDTH-1:ADC_WIDTH];
        end
    endgenerate

    assign w_accept = enable && s_axis_tvalid_adc && s_axis_tvalid_ref && (state_q == ST_ACCUM);
    assign cnt_d    = cnt_q + CNT_ONE;
    assign w_last   = (cnt_d == frame_len_q);

    // Both factors are sign-extended to the product width so the low bits of
    // the multiply are the exact signed product.
    assign w_adc_ext  = {{AXIS_TDATA_WIDTH{adc_q[ADC_WIDTH-1]}}, adc_q};
    assign w_ref_ext  = {{ADC_WIDTH{ref_q[AXIS_TDATA_WIDTH-1]}}, ref_q};
    assign w_prod     = w_adc_ext * w_ref_ext;
    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
    assign w_sum      = acc_q + w_prod_ext;
    assign w_close    = enable && s1_vld_q && s1_last_q;

    // Frame sequencer: counts accepted pairs and re-latches the frame length
    // at every frame boundary.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_len_q <= '0;
        end else if (!enable) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (n_samples != '0) begin
                        state_q     <= ST_ACCUM;
                        frame_len_q <= n_samples;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            cnt_q       <= '0;
                            frame_len_q <= n_samples;
                            if (n_samples == '0) begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Capture the accepted pair together with its end-of-frame tag.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            adc_q     <= '0;
            ref_q     <= '0;
            s0_vld_q  <= 1'b0;
            s0_last_q <= 1'b0;
        end else begin
            s0_vld_q  <= w_accept;
            s0_last_q <= w_accept && w_last;
            if (w_accept) begin
                adc_q <= s_axis_tdata_adc[ADC_WIDTH-1:0];
                ref_q <= s_axis_tdata_ref;
            end
        end
    end

    // Register the full-width signed product.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            prod_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
        end else begin
            s1_vld_q  <= enable && s0_vld_q;
            s1_last_q <= enable && s0_last_q;
            if (s0_vld_q) begin
                prod_q <= w_prod;
            end
        end
    end

    // Accumulate; the closing product restarts the sum from zero so the next
    // frame's first product (one edge later) lands on a clean accumulator.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
        end else if (!enable) begin
            acc_q <= '0;
        end else if (s1_vld_q) begin
            acc_q <= s1_last_q ? '0 : w_sum;
        end
    end

    // Output register with overwrite-on-stall and sticky overrun flag.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            res_q     <= '0;
            res_vld_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (w_close) begin
                res_q     <= w_sum;
                res_vld_q <= 1'b1;
            end else if (m_axis_tready) begin
                res_vld_q <= 1'b0;
            end
            if (!enable) begin
                overrun_q <= 1'b0;
            end else if (w_close && res_vld_q && !m_axis_tready) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign m_axis_tdata  = res_q;
    assign m_axis_tvalid = res_vld_q;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fourier_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fourier_analyzer
// Purpose  : Scoreboard bench for fourier_analyzer. A frame model pushes the
//            expected result (value and arrival edge) when the closing pair
//            is driven; results are popped when the DUT transfers them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fourier_analyzer;

    localparam int TW = 16;
    localparam int AW = 14;
    localparam int CW = 32;
    localparam int RW = 48;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [TW-1:0] adc_d;
    logic          adc_v;
    logic          adc_rdy;
    logic [TW-1:0] ref_d;
    logic          ref_v;
    logic          ref_rdy;
    logic [CW-1:0] n_samples;
    logic          enable;
    logic [RW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          overrun;

    typedef struct {
        logic signed [RW-1:0] val;
        int                   edge_n;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   npop  = 0;
    bit   chk_lat = 1'b1;
    logic signed [RW-1:0] last_pop;

    // Frame model state
    bit                   m_acc;
    logic [CW-1:0]        m_cnt;
    logic [CW-1:0]        m_flen;
    logic signed [RW-1:0] m_sum;

    always #5 clk = ~clk;

    fourier_analyzer #(
        .AXIS_TDATA_WIDTH(TW),
        .ADC_WIDTH       (AW),
        .CFG_DATA_WIDTH  (CW),
        .ACC_WIDTH       (RW)
    ) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .s_axis_tdata_adc (adc_d),
        .s_axis_tvalid_adc(adc_v),
        .s_axis_tready_adc(adc_rdy),
        .s_axis_tdata_ref (ref_d),
        .s_axis_tvalid_ref(ref_v),
        .s_axis_tready_ref(ref_rdy),
        .n_samples        (n_samples),
        .enable           (enable),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .overrun          (overrun)
    );

    // One clock: update the model with the inputs the coming edge sees,
    // score any transfer that edge performs, then advance past the edge.
    task automatic step();
        logic signed [AW-1:0] a;
        logic signed [TW-1:0] r;
        longint               p;
        exp_t                 e;
        if (!enable) begin
            m_acc = 1'b0;
            m_cnt = '0;
            m_sum = '0;
        end else if (!m_acc) begin
            if (n_samples != 0) begin
                m_acc  = 1'b1;
                m_flen = n_samples;
                m_cnt  = '0;
            end
        end else if (adc_v && ref_v) begin
            a     = adc_d[AW-1:0];
            r     = ref_d;
            p     = longint'(a) * longint'(r);
            m_sum = m_sum + p[RW-1:0];
            m_cnt = m_cnt + 1;
            if (m_cnt == m_flen) begin
                e.val    = m_sum;
                e.edge_n = cyc + 3;
                q.push_back(e);
                m_sum  = '0;
                m_cnt  = '0;
                m_flen = n_samples;
                if (n_samples == 0) m_acc = 1'b0;
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            total++;
            npop++;
            last_pop = m_axis_tdata;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: tdata=%0d arrived with empty scoreboard at edge %0d",
                         $signed(m_axis_tdata), cyc);
            end else begin
                e = q.pop_front();
                if (m_axis_tdata !== e.val) begin
                    bad++;
                    $display("FAIL result_value: got %0d expected %0d", $signed(m_axis_tdata), e.val);
                end
                if (chk_lat) begin
                    total++;
                    if (cyc != e.edge_n) begin
                        bad++;
                        $display("FAIL result_latency: appeared by edge %0d expected edge %0d", cyc, e.edge_n);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        adc_v = 1'b0;
        ref_v = 1'b0;
        repeat (4) step();
    endtask

    task automatic go_idle();
        adc_v  = 1'b0;
        ref_v  = 1'b0;
        enable = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        enable        = 1'b0;
        adc_d         = '0;
        ref_d         = '0;
        adc_v         = 1'b0;
        ref_v         = 1'b0;
        n_samples     = '0;
        m_axis_tready = 1'b1;
        m_acc = 1'b0; m_cnt = '0; m_flen = '0; m_sum = '0;
        #12;
        total++; if (m_axis_tdata !== '0) begin bad++; $display("FAIL reset_tdata: got %0h expected 0", m_axis_tdata); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        total++; if (adc_rdy !== 1'b1 || ref_rdy !== 1'b1) begin bad++; $display("FAIL reset_tready: got adc=%b ref=%b expected 1 1", adc_rdy, ref_rdy); end
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_basic();
        int p0;
        p0 = npop;
        n_samples = 4; adc_d = 16'd100; ref_d = 16'd200;
        adc_v = 1'b1; ref_v = 1'b1; enable = 1'b1;
        repeat (13) step();
        drain();
        total++; if (npop - p0 != 3) begin bad++; $display("FAIL basic_count: got %0d results expected 3", npop - p0); end
        total++; if (last_pop !== 48'sd80000) begin bad++; $display("FAIL basic_value: got %0d expected 80000", last_pop); end
        total++; if (q.size() != 0) begin bad++; $display("FAIL basic_leftover: %0d results missing", q.size()); end
        go_idle();
    endtask

    task automatic test_min_frame();
        int p0;
        p0 = npop;
        n_samples = 1; adc_d = 16'hE000; ref_d = 16'h8000;
        adc_v = 1'b1; ref_v = 1'b1; enable = 1'b1;
        repeat (5) step();
        ref_d = 16'h7FFF;
        repeat (4) step();
        drain();
        total++; if (npop - p0 != 8) begin bad++; $display("FAIL minframe_count: got %0d results expected 8", npop - p0); end
        total++; if (last_pop !== -48'sd268427264) begin bad++; $display("FAIL minframe_value: got %0d expected -268427264", last_pop); end
        go_idle();
    endtask

    task automatic test_valid_gating();
        int p0;
        p0 = npop;
        n_samples = 3; adc_d = 16'd1; ref_d = 16'd1;
        adc_v = 1'b1; ref_v = 1'b1; enable = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            adc_v = (i % 2 == 0);
            step();
        end
        drain();
        total++; if (npop - p0 != 1) begin bad++; $display("FAIL gating_count: got %0d results expected 1", npop - p0); end
        total++; if (last_pop !== 48'sd3) begin bad++; $display("FAIL gating_value: got %0d expected 3", last_pop); end
        go_idle();
    endtask

    task automatic test_overrun();
        n_samples = 2; adc_d = 16'd2; ref_d = 16'd3;
        m_axis_tready = 1'b0; chk_lat = 1'b0;
        adc_v = 1'b1; ref_v = 1'b1; enable = 1'b1;
        repeat (11) step();
        adc_v = 1'b0; ref_v = 1'b0;
        repeat (3) step();
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL ovr_tvalid_hold: got %b expected 1", m_axis_tvalid); end
        total++; if (m_axis_tdata !== 48'd12) begin bad++; $display("FAIL ovr_tdata_hold: got %0d expected 12", m_axis_tdata); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag_set: got %b expected 1", overrun); end
        while (q.size() > 1) void'(q.pop_front());
        m_axis_tready = 1'b1;
        step();
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL ovr_single_transfer: tvalid=%b expected 0", m_axis_tvalid); end
        step();
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        enable = 1'b0;
        step();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        chk_lat = 1'b1;
        go_idle();
    endtask

    task automatic test_abort();
        int p0;
        p0 = npop;
        n_samples = 4; adc_d = 16'd5; ref_d = 16'd7;
        adc_v = 1'b1; ref_v = 1'b1; enable = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        step();
        enable = 1'b1; adc_d = 16'd3; ref_d = -16'sd4;
        repeat (5) step();
        drain();
        total++; if (npop - p0 != 1) begin bad++; $display("FAIL abort_count: got %0d results expected 1", npop - p0); end
        total++; if (last_pop !== -48'sd48) begin bad++; $display("FAIL abort_value: got %0d expected -48", last_pop); end
        go_idle();

        // Asynchronous reset with a result held in the output register.
        n_samples = 2; adc_d = 16'd9; ref_d = 16'd9; m_axis_tready = 1'b0;
        adc_v = 1'b1; ref_v = 1'b1; enable = 1'b1;
        repeat (4) step();
        adc_v = 1'b0; ref_v = 1'b0;
        step();
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 48'd162) begin bad++; $display("FAIL prerst_result: tvalid=%b tdata=%0d expected 1 162", m_axis_tvalid, m_axis_tdata); end
        #2 aresetn = 1'b0;
        #1;
        total++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || overrun !== 1'b0) begin
            bad++; $display("FAIL async_reset: tvalid=%b tdata=%0d overrun=%b expected 0 0 0", m_axis_tvalid, m_axis_tdata, overrun);
        end
        q.delete();
        m_acc = 1'b0; m_cnt = '0; m_sum = '0;
        #1 aresetn = 1'b1;
        p0 = npop;
        m_axis_tready = 1'b1; adc_d = 16'd4; ref_d = 16'd5; adc_v = 1'b1; ref_v = 1'b1;
        repeat (3) step();
        drain();
        total++; if (npop - p0 != 1 || last_pop !== 48'sd40) begin bad++; $display("FAIL postrst_frame: count=%0d value=%0d expected 1 40", npop - p0, last_pop); end
        go_idle();
    endtask

    task automatic test_len_change();
        int p0;
        p0 = npop;
        n_samples = 0; adc_d = 16'd1; ref_d = 16'd1;
        adc_v = 1'b1; ref_v = 1'b1; enable = 1'b1;
        repeat (6) step();
        total++; if (m_axis_tvalid !== 1'b0 || npop != p0) begin bad++; $display("FAIL zero_len_idle: tvalid=%b results=%0d expected 0 0", m_axis_tvalid, npop - p0); end
        n_samples = 2; adc_d = 16'd0; ref_d = 16'd10;
        step();
        for (int i = 1; i <= 7; i++) begin
            adc_d = TW'(i);
            step();
            if (i == 1) n_samples = 5;
        end
        drain();
        total++; if (npop - p0 != 2) begin bad++; $display("FAIL lenchg_count: got %0d results expected 2", npop - p0); end
        total++; if (last_pop !== 48'sd250) begin bad++; $display("FAIL lenchg_value: got %0d expected 250", last_pop); end
        total++; if (q.size() != 0) begin bad++; $display("FAIL lenchg_leftover: %0d results missing", q.size()); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_frame();
        test_valid_gating();
        test_overrun();
        test_abort();
        test_len_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
